// File: rtl/alu_pkg.sv
// ----------------------------------------------------------------------------
// Module  : alu_pkg
// Brief   : Shared ALU opcode constants, result-entry width and entry typedef.
// Rev     : 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

package alu_pkg;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_REM = 2'b10,
        ALU_MUL = 2'b11
    } alu_op_e;

    localparam int ALU_DATA_W  = 4;
    localparam int ALU_FLAG_W  = 3;
    localparam int ALU_ENTRY_W = ALU_DATA_W + ALU_FLAG_W;

    // Field order matches the stored word: {result, sign, ovf, zero}.
    typedef struct packed {
        logic [ALU_DATA_W-1:0] result;
        logic                  sign;
        logic                  ovf;
        logic                  zero;
    } alu_entry_t;

endpackage

`default_nettype wire

// File: rtl/alu_sync_fifo.sv
// ----------------------------------------------------------------------------
// Module  : alu_sync_fifo
// Brief   : Show-ahead synchronous FIFO; storage, wrapping pointers, occupancy.
// Rev     : 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module alu_sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 7
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         wdata_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] c_FULL_CNT = DEPTH[PTR_W:0];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q,  count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];

    logic w_push;
    logic w_pop;

    assign full_o  = (count_q == c_FULL_CNT);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

    // Guarding here keeps the FIFO safe even if a caller forgets to.
    assign w_push = push_i & ~full_o;
    assign w_pop  = pop_i  & ~empty_o;

    // DEPTH is a power of two, so natural pointer overflow gives the wrap.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (w_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule

`default_nettype wire

// File: rtl/alu_result_buffer.sv
// ----------------------------------------------------------------------------
// Module  : alu_result_buffer
// Brief   : Buffers ALU results with flags; sticky drop error, optional
//           ovf/zero statistics enabled by macro ALU_RESULT_STATS_EN.
// Rev     : 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module alu_result_buffer
    import alu_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [DATA_W-1:0]        in_out,
    input  logic                     in_sign,
    input  logic                     in_ovf,
    input  logic                     in_zero,
    output logic                     in_ready,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_sign,
    output logic                     out_ovf,
    output logic                     out_zero,
    output logic [$clog2(DEPTH):0]   count,
`ifdef ALU_RESULT_STATS_EN
    output logic [7:0]               ovf_cnt,
    output logic [7:0]               zero_cnt,
`endif
    output logic                     drop_err
);

    localparam int c_ENTRY_W = DATA_W + ALU_FLAG_W;

    logic                 w_push;
    logic                 w_pop;
    logic                 w_full;
    logic                 w_empty;
    logic [c_ENTRY_W-1:0] w_wdata;
    logic [c_ENTRY_W-1:0] w_rdata;
    logic                 drop_err_q, drop_err_d;

    assign in_ready  = ~w_full;
    assign out_valid = ~w_empty;
    assign w_push    = in_valid & in_ready;
    assign w_pop     = out_valid & out_ready;
    assign w_wdata   = {in_out, in_sign, in_ovf, in_zero};

    alu_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (c_ENTRY_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (w_push),
        .pop_i   (w_pop),
        .wdata_i (w_wdata),
        .rdata_o (w_rdata),
        .count_o (count),
        .full_o  (w_full),
        .empty_o (w_empty)
    );

    // The FIFO already returns zero when empty, so no extra masking here.
    assign {out_data, out_sign, out_ovf, out_zero} = w_rdata;

    assign drop_err_d = drop_err_q | (in_valid & ~in_ready);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_err_q <= 1'b0;
        end else begin
            drop_err_q <= drop_err_d;
        end
    end

    assign drop_err = drop_err_q;

`ifdef ALU_RESULT_STATS_EN
    logic [7:0] ovf_cnt_q,  ovf_cnt_d;
    logic [7:0] zero_cnt_q, zero_cnt_d;

    // Only accepted pushes count; both counters saturate at 255.
    always_comb begin
        ovf_cnt_d  = ovf_cnt_q;
        zero_cnt_d = zero_cnt_q;
        if (w_push && in_ovf && (ovf_cnt_q != 8'hFF)) begin
            ovf_cnt_d = ovf_cnt_q + 8'd1;
        end
        if (w_push && in_zero && (zero_cnt_q != 8'hFF)) begin
            zero_cnt_d = zero_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_cnt_q  <= 8'd0;
            zero_cnt_q <= 8'd0;
        end else begin
            ovf_cnt_q  <= ovf_cnt_d;
            zero_cnt_q <= zero_cnt_d;
        end
    end

    assign ovf_cnt  = ovf_cnt_q;
    assign zero_cnt = zero_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_alu_result_buffer.sv
// ----------------------------------------------------------------------------
// Module  : tb_alu_result_buffer
// Brief   : Self-checking bench for alu_result_buffer against a queue model.
// Rev     : 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module tb_alu_result_buffer;

    localparam int DEPTH = 4;
    localparam int DW    = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic [DW-1:0] in_out;
    logic          in_sign, in_ovf, in_zero;
    logic          in_ready;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_sign, out_ovf, out_zero;
    logic [CW-1:0] count;
    logic          drop_err;
`ifdef ALU_RESULT_STATS_EN
    logic [7:0]    ovf_cnt, zero_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    alu_result_buffer #(.DEPTH(DEPTH), .DATA_W(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_out    (in_out),
        .in_sign   (in_sign),
        .in_ovf    (in_ovf),
        .in_zero   (in_zero),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sign  (out_sign),
        .out_ovf   (out_ovf),
        .out_zero  (out_zero),
        .count     (count),
`ifdef ALU_RESULT_STATS_EN
        .ovf_cnt   (ovf_cnt),
        .zero_cnt  (zero_cnt),
`endif
        .drop_err  (drop_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: an ordered queue of {result,sign,ovf,zero} words.
    logic [DW+2:0] mq[$];
    bit            m_drop;
    int            m_ovf, m_zero;
    bit            m_push;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            m_drop = 1'b0;
            m_ovf  = 0;
            m_zero = 0;
        end else begin
            m_push = in_valid && (mq.size() < DEPTH);
            if (in_valid && !m_push) m_drop = 1'b1;
            if (out_ready && mq.size() > 0) void'(mq.pop_front());
            if (m_push) begin
                mq.push_back({in_out, in_sign, in_ovf, in_zero});
                if (in_ovf  && m_ovf  < 255) m_ovf++;
                if (in_zero && m_zero < 255) m_zero++;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en && !rst) begin
            logic [DW+2:0] head;
            head = (mq.size() > 0) ? mq[0] : '0;
            check("count",     32'(count),     32'(mq.size()));
            check("in_ready",  32'(in_ready),  32'(mq.size() != DEPTH));
            check("out_valid", 32'(out_valid), 32'(mq.size() != 0));
            check("out_word",  32'({out_data, out_sign, out_ovf, out_zero}), 32'(head));
            check("drop_err",  32'(drop_err),  32'(m_drop));
`ifdef ALU_RESULT_STATS_EN
            check("ovf_cnt",   32'(ovf_cnt),   32'(m_ovf));
            check("zero_cnt",  32'(zero_cnt),  32'(m_zero));
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic v, input logic [DW-1:0] d,
                          input logic s, input logic o, input logic z);
        in_valid = v;
        in_out   = d;
        in_sign  = s;
        in_ovf   = o;
        in_zero  = z;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        out_ready = 1'b0;
        set_in(1'b0, '0, 1'b0, 1'b0, 1'b0);
        #2;
        check("rst_count",     32'(count),     32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data",  32'(out_data),  32'd0);
        check("rst_drop_err",  32'(drop_err),  32'd0);
        tick();
        rst = 1'b0;
        chk_en = 1'b1;

        // Single push becomes visible after one edge.
        set_in(1'b1, 4'b0011, 1'b0, 1'b0, 1'b0);
        tick();
        set_in(1'b0, '0, 1'b0, 1'b0, 1'b0);
        check("first_valid", 32'(out_valid), 32'd1);
        check("first_data",  32'(out_data),  32'h3);
        check("first_count", 32'(count),     32'd1);

        // Fill to full then drain in order.
        pulse_reset();
        for (int i = 1; i <= 4; i++) begin
            set_in(1'b1, 4'(i), 1'b0, 1'b0, 1'b0);
            tick();
        end
        set_in(1'b0, '0, 1'b0, 1'b0, 1'b0);
        check("full_count",    32'(count),    32'd4);
        check("full_in_ready", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            check("drain_data", 32'(out_data), 32'(i));
            tick();
        end
        out_ready = 1'b0;
        check("drain_empty", 32'(out_valid), 32'd0);

        // Full with push and pop together: push dropped, pop proceeds.
        pulse_reset();
        for (int i = 5; i <= 8; i++) begin
            set_in(1'b1, 4'(i), 1'b1, 1'b0, 1'b0);
            tick();
        end
        set_in(1'b1, 4'h9, 1'b0, 1'b0, 1'b0);
        out_ready = 1'b1;
        tick();
        set_in(1'b0, '0, 1'b0, 1'b0, 1'b0);
        out_ready = 1'b0;
        check("fullpp_count", 32'(count),    32'd3);
        check("fullpp_drop",  32'(drop_err), 32'd1);
        check("fullpp_head",  32'(out_data), 32'h6);

        // Mid-stream asynchronous reset with count=3 and drop_err set.
        rst = 1'b1;
        #1;
        check("arst_count", 32'(count),     32'd0);
        check("arst_valid", 32'(out_valid), 32'd0);
        check("arst_drop",  32'(drop_err),  32'd0);
        rst = 1'b0;
        set_in(1'b1, 4'hA, 1'b0, 1'b1, 1'b1);
        tick();
        set_in(1'b0, '0, 1'b0, 1'b0, 1'b0);
        check("post_rst_count", 32'(count),    32'd1);
        check("post_rst_data",  32'(out_data), 32'hA);

        // Half full steady state: push+pop every cycle for 10 cycles.
        pulse_reset();
        set_in(1'b1, 4'd1, 1'b0, 1'b0, 1'b0);
        tick();
        set_in(1'b1, 4'd2, 1'b0, 1'b0, 1'b0);
        tick();
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            set_in(1'b1, 4'(3 + i), 1'b0, 1'b0, 1'b0);
            tick();
            check("half_count", 32'(count), 32'd2);
        end
        set_in(1'b0, '0, 1'b0, 1'b0, 1'b0);
        out_ready = 1'b0;
        check("half_head", 32'(out_data), 32'hB);

        // Randomized traffic with phases of differing pressure.
        pulse_reset();
        for (int i = 0; i < 3000; i++) begin
            int phase;
            phase = (i / 250) % 3;
            set_in(($urandom_range(0, 3) < (phase == 0 ? 3 : 1)),
                   4'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            out_ready = ($urandom_range(0, 3) < (phase == 1 ? 3 : 2));
            if ($urandom_range(0, 499) == 0) begin
                pulse_reset();
            end
            tick();
        end
        set_in(1'b0, '0, 1'b0, 1'b0, 1'b0);
        out_ready = 1'b0;

`ifdef ALU_RESULT_STATS_EN
        // 300 accepted overflow pushes saturate the counter.
        pulse_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            set_in(1'b1, 4'($urandom), 1'b0, 1'b1, 1'b0);
            tick();
        end
        set_in(1'b0, '0, 1'b0, 1'b0, 1'b0);
        out_ready = 1'b0;
        check("ovf_sat", 32'(ovf_cnt), 32'd255);

        // Rejected pushes are not counted.
        pulse_reset();
        for (int i = 0; i < 7; i++) begin
            set_in(1'b1, 4'(i), 1'b0, 1'b0, 1'b1);
            tick();
        end
        set_in(1'b0, '0, 1'b0, 1'b0, 1'b0);
        check("zero_rejected", 32'(zero_cnt), 32'd4);
        check("zero_drop",     32'(drop_err), 32'd1);
`endif

        tick();
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/alu_result_buffer.md
ALU_RESULT_BUFFER -- requirements
Module: alu_result_buffer

Interface
REQ-001 Parameter DEPTH, default 4, number of FIFO entries; SHALL be a power of two, 2..16.
REQ-002 Parameter DATA_W, default 4, width of the ALU result field.
REQ-003 Port clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 Port rst  input  1  asynchronous, active-high reset.
REQ-005 Port in_valid  input  1  ALU result presented this cycle.
REQ-006 Port in_out  input  DATA_W  ALU result value.
REQ-007 Port in_sign, in_ovf, in_zero  input  1 each  ALU sign, overflow and zero flags.
REQ-008 Port in_ready  output  1  buffer can accept a result.
REQ-009 Port out_valid  output  1  head entry available.
REQ-010 Port out_ready  input  1  consumer takes the head entry.
REQ-011 Port out_data  output  DATA_W  head result; out_sign, out_ovf, out_zero  output  1 each  head flags.
REQ-012 Port count  output  clog2(DEPTH)+1  current occupancy.
REQ-013 Port drop_err  output  1  sticky: a result was lost.

Function
REQ-014 Each entry SHALL store {result, sign, ovf, zero} as one (DATA_W+3)-bit word.
REQ-015 Push SHALL occur on a clock edge when in_valid && in_ready; pop SHALL occur when out_valid && out_ready.
REQ-016 in_ready SHALL equal (count != DEPTH), derived from registered state only.
REQ-017 out_valid SHALL equal (count != 0); out_* fields SHALL show the head entry (show-ahead), and SHALL be 0 when empty.
REQ-018 Latency: a result pushed at edge N SHALL be visible on out_* with out_valid=1 after edge N; there SHALL be no combinational in->out bypass.
REQ-019 Write and read pointers SHALL wrap modulo DEPTH; count SHALL change by +1 (push only), -1 (pop only), or 0 (both or neither).
REQ-020 When full, in_valid=1 with simultaneous pop: push SHALL be rejected (in_ready is 0); the pop SHALL proceed.
REQ-021 When empty, out_ready=1 SHALL have no effect.
REQ-022 in_valid=1 while in_ready=0 SHALL set drop_err at that edge; drop_err SHALL remain 1 until reset.
REQ-023 Entries SHALL be delivered strictly in push order, with fields unmodified.

Reset
REQ-024 On rst=1, asynchronously: pointers=0, count=0, out_valid=0, in_ready=1, out_* =0, drop_err=0, statistics counters=0.
REQ-025 Reset asserted mid-operation SHALL discard all stored entries; storage array contents need not be cleared.
REQ-026 First push after rst deassertion SHALL be accepted on the first rising edge.

Configuration
REQ-027 Macro ALU_RESULT_STATS_EN, when defined, SHALL add outputs ovf_cnt[7:0] and zero_cnt[7:0], counting accepted pushes with in_ovf=1 / in_zero=1, saturating at 255.
REQ-028 Without ALU_RESULT_STATS_EN, those ports and counters SHALL not exist; all other behaviour SHALL be identical.

Structure
REQ-029 A shared package alu_pkg SHALL hold the ALU opcode constants (ADD=00, SUB=01, REM=10, MUL=11), the result-entry width constant and the packed-entry typedef.
REQ-030 Storage plus pointers SHALL be a sub-module alu_sync_fifo; alu_result_buffer SHALL add packing, drop_err and statistics.

Verification
REQ-031 Reset then push in_out=0011, ovf=0, zero=0 -> next cycle out_valid=1, out_data=0011, count=1.
REQ-032 Push 4 entries (0001,0010,0011,0100) with out_ready=0 -> count=4, in_ready=0; drain -> outputs in order 0001..0100, then out_valid=0.
REQ-033 Full, in_valid=1 and out_ready=1 in the same cycle -> count=3, drop_err=1, head advances by one.
REQ-034 Half full, push and pop in the same cycle for 10 cycles -> count constant, pointers wrap, data order preserved.
REQ-035 Assert rst mid-stream with count=3 -> immediately count=0, out_valid=0, drop_err=0; the next push is accepted.
REQ-036 With ALU_RESULT_STATS_EN: 300 accepted pushes with in_ovf=1 -> ovf_cnt=255; rejected pushes are not counted.
